// File: rtl/px_out_serializer_pkg.sv
// Shared definitions for the pixel output serializer: mode encodings,
// output byte width and the byte-sender FSM state type.
package px_out_serializer_pkg;

    localparam int BYTE_W = 8;
    localparam int NB_W   = 2;

    localparam logic [1:0] MODE_GRAY       = 2'b00;
    localparam logic [1:0] MODE_SOBEL      = 2'b01;
    localparam logic [1:0] MODE_GRAY_SOBEL = 2'b10;
    localparam logic [1:0] MODE_BYPASS     = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    // RGB bypass carries three bytes; every other mode carries one.
    function automatic logic [NB_W-1:0] nbytes_for(input logic [1:0] mode);
        return (mode == MODE_BYPASS) ? NB_W'(3) : NB_W'(1);
    endfunction

endpackage

// File: rtl/px_fifo.sv
// Synchronous FIFO with flush; a push into a full FIFO is accepted only when a
// pop happens in the same cycle.
module px_fifo #(
    parameter int WIDTH = 26,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     nreset_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             push_ok, pop_ok;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LW'(DEPTH));
    assign level_o = level_q;
    assign rdata_o = mem_q[rptr_q];

    assign pop_ok  = pop_i && !empty_o && !flush_i;
    assign push_ok = push_i && !flush_i && (!full_o || pop_ok);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
        end else begin
            if (push_ok) wptr_d = wptr_q + AW'(1);
            if (pop_ok)  rptr_d = rptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/px_out_serializer.sv
// Buffers processed pixels and re-emits them LSB-first as 8-bit bytes over a
// valid/ack handshake; byte count per pixel is captured from mode_i at push.
module px_out_serializer
    import px_out_serializer_pkg::*;
#(
    parameter int PX_BITS    = 24,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          nreset_i,
    input  logic                          clear_i,
    input  logic [1:0]                    mode_i,
    input  logic [PX_BITS-1:0]            px_i,
    input  logic                          px_valid_i,
    output logic [BYTE_W-1:0]             byte_o,
    output logic                          byte_valid_o,
    input  logic                          byte_ack_i,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          overflow_o
);
    localparam int ENTRY_W = PX_BITS + NB_W;

    state_e               state_q, state_d;
    logic [PX_BITS-1:0]   shift_q, shift_d;
    logic [NB_W-1:0]      cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;

    logic                 pop;
    logic                 fifo_full, fifo_empty;
    logic [ENTRY_W-1:0]   head, wentry;

    assign wentry = {nbytes_for(mode_i), px_i};

    px_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i    (clk_i),
        .nreset_i (nreset_i),
        .flush_i  (clear_i),
        .push_i   (px_valid_i),
        .wdata_i  (wentry),
        .pop_i    (pop),
        .rdata_o  (head),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty),
        .level_o  (level_o)
    );

    assign byte_o       = shift_q[BYTE_W-1:0];
    assign byte_valid_o = (state_q == ST_SEND);
    assign overflow_o   = ovf_q;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = head[PX_BITS-1:0];
                    cnt_d   = head[ENTRY_W-1:PX_BITS];
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (byte_ack_i) begin
                    if (cnt_q > NB_W'(1)) begin
                        shift_d = shift_q >> BYTE_W;
                        cnt_d   = cnt_q - NB_W'(1);
                    end else if (!fifo_empty) begin
                        // Chain straight into the next pixel without an idle bubble.
                        pop     = 1'b1;
                        shift_d = head[PX_BITS-1:0];
                        cnt_d   = head[ENTRY_W-1:PX_BITS];
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (clear_i) begin
            state_d = ST_IDLE;
            pop     = 1'b0;
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        if (clear_i) begin
            ovf_d = 1'b0;
        end else if (px_valid_i && fifo_full && !pop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_px_out_serializer.sv
// Scoreboard bench for px_out_serializer: expected bytes are queued when pixels
// are strobed and checked against each accepted byte.
module tb_px_out_serializer;

    logic        clk_i = 1'b0;
    logic        nreset_i;
    logic        clear_i;
    logic [1:0]  mode_i;
    logic [23:0] px_i;
    logic        px_valid_i;
    logic [7:0]  byte_o;
    logic        byte_valid_o;
    logic        byte_ack_i;
    logic [2:0]  level_o;
    logic        overflow_o;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] sb_q [$];

    px_out_serializer #(
        .PX_BITS    (24),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_i        (clk_i),
        .nreset_i     (nreset_i),
        .clear_i      (clear_i),
        .mode_i       (mode_i),
        .px_i         (px_i),
        .px_valid_i   (px_valid_i),
        .byte_o       (byte_o),
        .byte_valid_o (byte_valid_o),
        .byte_ack_i   (byte_ack_i),
        .level_o      (level_o),
        .overflow_o   (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs only change 1 time unit after a rising edge, so the values seen at
    // the falling edge are the ones the next rising edge will act on.
    always @(negedge clk_i) begin
        if (nreset_i && !clear_i && byte_valid_o && byte_ack_i) begin
            if (sb_q.size() == 0) begin
                chk("extra_byte", {24'd0, byte_o}, 32'hFFFF_FFFF);
            end else begin
                chk("byte", {24'd0, byte_o}, {24'd0, sb_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_px(input logic [1:0] mode, input logic [23:0] px, input bit dropped);
        mode_i     = mode;
        px_i       = px;
        px_valid_i = 1'b1;
        if (!dropped) begin
            sb_q.push_back(px[7:0]);
            if (mode == 2'b11) begin
                sb_q.push_back(px[15:8]);
                sb_q.push_back(px[23:16]);
            end
        end
        tick();
        px_valid_i = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            if (sb_q.size() == 0 && !byte_valid_o && level_o == 3'd0) done = 1'b1;
            else tick();
        end
        chk(tag, {31'd0, done}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nreset_i   = 1'b0;
        clear_i    = 1'b0;
        mode_i     = 2'b00;
        px_i       = '0;
        px_valid_i = 1'b0;
        byte_ack_i = 1'b0;
        repeat (3) tick();
        chk("rst_valid", {31'd0, byte_valid_o}, 32'd0);
        chk("rst_byte", {24'd0, byte_o}, 32'd0);
        chk("rst_level", {29'd0, level_o}, 32'd0);
        chk("rst_ovf", {31'd0, overflow_o}, 32'd0);
        nreset_i = 1'b1;
        tick();

        // Single Sobel pixel: latency of two edges, one byte out
        byte_ack_i = 1'b1;
        push_px(2'b01, 24'h0000A5, 1'b0);
        chk("lat_level1", {29'd0, level_o}, 32'd1);
        chk("lat_novalid", {31'd0, byte_valid_o}, 32'd0);
        tick();
        chk("lat_valid", {31'd0, byte_valid_o}, 32'd1);
        chk("lat_byte", {24'd0, byte_o}, 32'hA5);
        chk("lat_level0", {29'd0, level_o}, 32'd0);
        tick();
        chk("single_done", {31'd0, byte_valid_o}, 32'd0);
        wait_drain("drain_single", 10);

        // RGB pixel with ack held: three consecutive bytes
        push_px(2'b11, 24'h123456, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rgb_valid", {31'd0, byte_valid_o}, 32'd1);
        end
        tick();
        chk("rgb_end", {31'd0, byte_valid_o}, 32'd0);
        wait_drain("drain_rgb", 10);

        // Ack stall holds the first byte stable
        byte_ack_i = 1'b0;
        push_px(2'b11, 24'h123456, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", {31'd0, byte_valid_o}, 32'd1);
            chk("stall_byte", {24'd0, byte_o}, 32'h56);
            tick();
        end
        byte_ack_i = 1'b1;
        wait_drain("drain_stall", 20);

        // Overflow: six Sobel pixels with ack low, the sixth is dropped
        byte_ack_i = 1'b0;
        for (int i = 1; i <= 6; i++) push_px(2'b01, 24'(i), i == 6);
        chk("ovf_level", {29'd0, level_o}, 32'd4);
        chk("ovf_flag", {31'd0, overflow_o}, 32'd1);
        byte_ack_i = 1'b1;
        wait_drain("drain_ovf", 30);
        chk("ovf_sticky", {31'd0, overflow_o}, 32'd1);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        chk("ovf_cleared", {31'd0, overflow_o}, 32'd0);

        // Mode switch while queue occupied
        byte_ack_i = 1'b0;
        push_px(2'b11, 24'hAABBCC, 1'b0);
        push_px(2'b00, 24'h00007F, 1'b0);
        mode_i = 2'b11;
        byte_ack_i = 1'b1;
        wait_drain("drain_mode", 30);

        // Back-to-back gray pixels: one byte per cycle
        push_px(2'b00, 24'h000011, 1'b0);
        push_px(2'b10, 24'h000022, 1'b0);
        push_px(2'b00, 24'h000033, 1'b0);
        chk("b2b_valid0", {31'd0, byte_valid_o}, 32'd1);
        tick();
        chk("b2b_valid1", {31'd0, byte_valid_o}, 32'd1);
        wait_drain("drain_b2b", 20);

        // clear_i mid-RGB together with a pixel strobe
        push_px(2'b11, 24'h112233, 1'b0);
        tick();
        tick();
        chk("clr_mid_valid", {31'd0, byte_valid_o}, 32'd1);
        chk("clr_mid_byte", {24'd0, byte_o}, 32'h22);
        clear_i    = 1'b1;
        mode_i     = 2'b00;
        px_i       = 24'h000099;
        px_valid_i = 1'b1;
        sb_q.delete();
        tick();
        clear_i    = 1'b0;
        px_valid_i = 1'b0;
        chk("clr_valid", {31'd0, byte_valid_o}, 32'd0);
        chk("clr_level", {29'd0, level_o}, 32'd0);
        chk("clr_ovf", {31'd0, overflow_o}, 32'd0);
        repeat (4) tick();
        chk("clr_quiet", {31'd0, byte_valid_o}, 32'd0);

        // Async reset pulse mid-transfer
        push_px(2'b11, 24'h445566, 1'b0);
        tick();
        tick();
        nreset_i = 1'b0;
        sb_q.delete();
        #2;
        chk("arst_valid", {31'd0, byte_valid_o}, 32'd0);
        chk("arst_level", {29'd0, level_o}, 32'd0);
        chk("arst_byte", {24'd0, byte_o}, 32'd0);
        tick();
        nreset_i = 1'b1;
        repeat (4) tick();
        chk("arst_quiet", {31'd0, byte_valid_o}, 32'd0);
        chk("sb_left", sb_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
